cpu_id_pipe: RTL and testbench
==============================

CPU_ID_PIPE -- requirements
Module: cpu_id_pipe

Interface
REQ-001 SHALL have parameter NREG, default 32: implemented registers (2..32); addresses >= NREG read 0 and drop writes.
REQ-002 SHALL have parameter BYPASS, default 1: 1 = WB write visible to same-cycle ID read; 0 = ID stalls instead.
REQ-003 SHALL have parameter RF_RESET, default 0: 1 = all registers cleared by reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port if_valid  input  1  IF/ID holds a real instruction.
REQ-007 SHALL have port if_pc  input  32  address of if_inst.
REQ-008 SHALL have port if_inst  input  32  instruction to decode.
REQ-009 SHALL have port wb_rfw  input  1  writeback enable.
REQ-010 SHALL have port wb_rf_waddr  input  5  writeback register.
REQ-011 SHALL have port wb_rf_wdata  input  32  writeback data.
REQ-012 SHALL have port id_stall  output  1  IF must hold if_pc/if_inst this cycle.
REQ-013 SHALL have port redirect  output  1  taken branch/jump; IF loads redirect_pc next edge.
REQ-014 SHALL have port redirect_pc  output  32  next-fetch address.
REQ-015 SHALL have port p_valid  output  1  ID/EX holds a real instruction.
REQ-016 SHALL have port p_opcode  output  6  registered opcode.
REQ-017 SHALL have port p_rfa  output  32  rs operand.
REQ-018 SHALL have port p_rfb  output  32  rt operand.
REQ-019 SHALL have port p_imm  output  32  extended immediate; [10:6] = shamt, [5:0] = func.
REQ-020 SHALL have port p_rf_waddr  output  5  destination register.
REQ-021 SHALL have port p_c_rfw  output  1  register write.
REQ-022 SHALL have port p_c_drw  output  1  data memory write.
REQ-023 SHALL have port p_c_wbsource  output  2  00 ALU, 01 memory, 10 p_jalra.
REQ-024 SHALL have port p_c_alusrc  output  1  ALU B = p_imm.
REQ-025 SHALL have port p_jalra  output  32  if_pc+4.

Function
REQ-026 SHALL decode op 0x00: waddr=rd, rfw=1; func 0x08 (jr): rfw=0, redirect to rs.
REQ-027 SHALL decode ops 0x08-0x0b: sign-extend; ops 0x0c-0x0f: zero-extend; both waddr=rt, rfw=1, alusrc=1.
REQ-028 SHALL decode lw 0x23: rt, rfw=1, alusrc=1, wbsource=01, sign-extend; sw 0x2b: drw=1, alusrc=1, sign-extend.
REQ-029 SHALL resolve beq 0x04/bne 0x05 in ID on bypassed operands; taken: redirect_pc = if_pc+4+(sext(imm)<<2).
REQ-030 SHALL treat j 0x02/jal 0x03 as redirect_pc = {(if_pc+4)[31:28], inst[25:0], 2'b00}; jal: waddr=31, rfw=1, wbsource=10; no delay slot.
REQ-031 SHALL register undefined opcodes as bubbles: p_valid=0, rfw=0, drw=0.
REQ-032 SHALL read register 0 as 0; write on posedge when wb_rfw, waddr!=0, waddr<NREG, regardless of stall.
REQ-033 SHALL use rs as a source for all ops except j/jal, and rt only for op 0x00, sw, beq, bne.
REQ-034 SHALL assert id_stall (load-use) when p_valid, p_c_wbsource=01, p_rf_waddr!=0, matching a used source.
REQ-035 SHALL assert id_stall when beq/bne/jr source matches p_rf_waddr!=0 with p_valid and p_c_rfw.
REQ-036 SHALL, with BYPASS=0, also assert id_stall when wb_rfw and wb_rf_waddr!=0 match a used source.
REQ-037 SHALL, during stall, load a bubble into ID/EX and hold redirect=0; stall re-evaluates each cycle.
REQ-038 SHALL run a two-state FSM RUN/KILL: decoded redirect in RUN -> KILL; in KILL, if_inst is a bubble, id_stall=0 -> RUN.
REQ-039 SHALL treat if_valid=0 as a bubble with id_stall=0 and redirect=0.

Reset
REQ-040 SHALL, while rst_n=0, force every p_* output to 0, FSM to RUN, and id_stall, redirect and redirect_pc to 0; clear registers only when RF_RESET=1.

Verification
REQ-041 SHALL pass: rst_n low mid-stream -> all p_* 0 immediately; RF_RESET=1 -> r7 reads 0 after release.
REQ-042 SHALL pass: WB r5=0x1234 while ID decodes addu rs=5 -> p_rfa=0x1234 (BYPASS=1); BYPASS=0 -> 1 stall cycle, then p_rfa=0x1234.
REQ-043 SHALL pass: lw r2 then addu r3,r2,r4 -> id_stall 1 cycle, p_valid=0 bubble, then addu issues.
REQ-044 SHALL pass: beq r1,r1, imm=3 at pc 0x100 -> redirect=1, redirect_pc=0x110, next ID/EX p_valid=0.
REQ-045 SHALL pass: jal target 0x40 at pc 0x200 -> redirect_pc=0x100, p_rf_waddr=31, p_jalra=0x204, p_c_wbsource=10.
REQ-046 SHALL pass: NREG=16 -> write 0xFFFF to r20 is dropped; read of r20 yields 0.

Source files
------------

// File: rtl/cpu_id_pipe.sv
`timescale 1ns/1ps
// cpu_id_pipe: decode stage of a 5-stage MIPS-style pipeline. Holds the register file,
// detects hazards, resolves branches/jumps in ID and drives the ID/EX register.
module cpu_id_pipe #(
  parameter int NREG     = 32,
  parameter int BYPASS   = 1,
  parameter int RF_RESET = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        wb_rfw,
  input  logic [4:0]  wb_rf_waddr,
  input  logic [31:0] wb_rf_wdata,
  output logic        id_stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        p_valid,
  output logic [5:0]  p_opcode,
  output logic [31:0] p_rfa,
  output logic [31:0] p_rfb,
  output logic [31:0] p_imm,
  output logic [4:0]  p_rf_waddr,
  output logic        p_c_rfw,
  output logic        p_c_drw,
  output logic [1:0]  p_c_wbsource,
  output logic        p_c_alusrc,
  output logic [31:0] p_jalra
);
  // state | meaning
  // RUN   | decode if_inst normally
  // KILL  | squash the fall-through instruction fetched before a redirect took effect
  typedef enum logic {ST_RUN = 1'b0, ST_KILL = 1'b1} state_t;

  localparam logic [5:0] NREG_W     = 6'(NREG);
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [1:0] WB_ALU     = 2'b00;
  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam logic [1:0] WB_LINK    = 2'b10;

  state_t state, state_nxt;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] pc4;

  assign op    = if_inst[31:26];
  assign rs    = if_inst[25:21];
  assign rt    = if_inst[20:16];
  assign rd    = if_inst[15:11];
  assign fn    = if_inst[5:0];
  assign imm16 = if_inst[15:0];
  assign pc4   = if_pc + 32'd4;

  logic [31:0] rf [32];
  logic        wr_en;

  assign wr_en = wb_rfw && (wb_rf_waddr != 5'd0) && ({1'b0, wb_rf_waddr} < NREG_W);

  generate
    if (RF_RESET != 0) begin : g_rf_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wr_en) begin
          rf[wb_rf_waddr] <= wb_rf_wdata;
        end
      end
    end else begin : g_rf_norst
      always_ff @(posedge clk) begin
        if (wr_en) rf[wb_rf_waddr] <= wb_rf_wdata;
      end
    end
  endgenerate

  // Read ports; with BYPASS the word being written this edge is forwarded.
  logic [31:0] rs_val, rt_val;

  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0 && {1'b0, rs} < NREG_W)
      rs_val = (BYPASS != 0 && wr_en && wb_rf_waddr == rs) ? wb_rf_wdata : rf[rs];
    if (rt != 5'd0 && {1'b0, rt} < NREG_W)
      rt_val = (BYPASS != 0 && wr_en && wb_rf_waddr == rt) ? wb_rf_wdata : rf[rt];
  end

  logic       d_def, d_rfw, d_drw, d_alusrc, d_zext, d_jump, d_jr, d_br, use_rs, use_rt;
  logic [1:0] d_wbsrc;
  logic [4:0] d_waddr;

  always_comb begin
    d_def    = 1'b0;
    d_rfw    = 1'b0;
    d_drw    = 1'b0;
    d_alusrc = 1'b0;
    d_zext   = 1'b0;
    d_jump   = 1'b0;
    d_jr     = 1'b0;
    d_br     = 1'b0;
    use_rt   = 1'b0;
    d_wbsrc  = WB_ALU;
    d_waddr  = 5'd0;
    case (op)
      OP_SPECIAL: begin
        d_def  = 1'b1;
        use_rt = 1'b1;
        if (fn == FN_JR) begin
          d_jr = 1'b1;
        end else begin
          d_rfw   = 1'b1;
          d_waddr = rd;
        end
      end
      OP_J: begin
        d_def  = 1'b1;
        d_jump = 1'b1;
      end
      OP_JAL: begin
        d_def   = 1'b1;
        d_jump  = 1'b1;
        d_rfw   = 1'b1;
        d_waddr = 5'd31;
        d_wbsrc = WB_LINK;
      end
      OP_BEQ, OP_BNE: begin
        d_def  = 1'b1;
        d_br   = 1'b1;
        use_rt = 1'b1;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        d_def    = 1'b1;
        d_rfw    = 1'b1;
        d_waddr  = rt;
        d_alusrc = 1'b1;
        d_zext   = op[2];
      end
      OP_LW: begin
        d_def    = 1'b1;
        d_rfw    = 1'b1;
        d_waddr  = rt;
        d_alusrc = 1'b1;
        d_wbsrc  = WB_MEM;
      end
      OP_SW: begin
        d_def    = 1'b1;
        d_drw    = 1'b1;
        d_alusrc = 1'b1;
        use_rt   = 1'b1;
      end
      default: ;
    endcase
  end

  assign use_rs = !(op == OP_J || op == OP_JAL);

  logic        hit_p, load_use, ctrl_hz, wb_hz, hazard, take;
  logic [31:0] target, imm_ext;

  always_comb begin
    hit_p    = (p_rf_waddr != 5'd0) &&
               ((use_rs && rs == p_rf_waddr) || (use_rt && rt == p_rf_waddr));
    load_use = p_valid && p_c_wbsource == WB_MEM && hit_p;
    // Branch compare needs final operand values, so any in-flight ALU result stalls it.
    ctrl_hz  = p_valid && p_c_rfw && p_rf_waddr != 5'd0 &&
               ((d_br && (rs == p_rf_waddr || rt == p_rf_waddr)) ||
                (d_jr && rs == p_rf_waddr));
    wb_hz    = (BYPASS == 0) && wb_rfw && wb_rf_waddr != 5'd0 &&
               ((use_rs && rs == wb_rf_waddr) || (use_rt && rt == wb_rf_waddr));
    hazard   = load_use || ctrl_hz || wb_hz;
    take     = d_jump || d_jr || (d_br && ((op == OP_BEQ) == (rs_val == rt_val)));
    imm_ext  = d_zext ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};
    if (d_jump)    target = {pc4[31:28], if_inst[25:0], 2'b00};
    else if (d_jr) target = rs_val;
    else           target = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  end

  logic live, issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (redirect) state_nxt = ST_KILL;
      ST_KILL: state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    live        = rst_n && if_valid && (state == ST_RUN);
    id_stall    = live && hazard;
    redirect    = live && !hazard && take;
    redirect_pc = redirect ? target : '0;
    issue       = live && !hazard && d_def;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !issue) begin
      p_valid      <= 1'b0;
      p_opcode     <= '0;
      p_rfa        <= '0;
      p_rfb        <= '0;
      p_imm        <= '0;
      p_rf_waddr   <= '0;
      p_c_rfw      <= 1'b0;
      p_c_drw      <= 1'b0;
      p_c_wbsource <= WB_ALU;
      p_c_alusrc   <= 1'b0;
      p_jalra      <= '0;
    end else begin
      p_valid      <= 1'b1;
      p_opcode     <= op;
      p_rfa        <= rs_val;
      p_rfb        <= rt_val;
      p_imm        <= imm_ext;
      p_rf_waddr   <= d_waddr;
      p_c_rfw      <= d_rfw;
      p_c_drw      <= d_drw;
      p_c_wbsource <= d_wbsrc;
      p_c_alusrc   <= d_alusrc;
      p_jalra      <= pc4;
    end
  end

endmodule

// File: tb/tb_cpu_id_pipe.sv
`timescale 1ns/1ps
// Directed bench for cpu_id_pipe: instance a uses defaults, instance b uses
// NREG=16, BYPASS=0, RF_RESET=1; both share the same stimulus.
module tb_cpu_id_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0, if_inst = '0;
  logic        wb_rfw = 1'b0;
  logic [4:0]  wb_rf_waddr = '0;
  logic [31:0] wb_rf_wdata = '0;

  logic        a_id_stall, a_redirect, a_p_valid, a_p_c_rfw, a_p_c_drw, a_p_c_alusrc;
  logic [31:0] a_redirect_pc, a_p_rfa, a_p_rfb, a_p_imm, a_p_jalra;
  logic [5:0]  a_p_opcode;
  logic [4:0]  a_p_rf_waddr;
  logic [1:0]  a_p_c_wbsource;
  logic        b_id_stall, b_redirect, b_p_valid, b_p_c_rfw, b_p_c_drw, b_p_c_alusrc;
  logic [31:0] b_redirect_pc, b_p_rfa, b_p_rfb, b_p_imm, b_p_jalra;
  logic [5:0]  b_p_opcode;
  logic [4:0]  b_p_rf_waddr;
  logic [1:0]  b_p_c_wbsource;

  cpu_id_pipe #(.NREG(32), .BYPASS(1), .RF_RESET(0)) u_a (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .wb_rfw(wb_rfw), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
    .id_stall(a_id_stall), .redirect(a_redirect), .redirect_pc(a_redirect_pc),
    .p_valid(a_p_valid), .p_opcode(a_p_opcode), .p_rfa(a_p_rfa), .p_rfb(a_p_rfb),
    .p_imm(a_p_imm), .p_rf_waddr(a_p_rf_waddr), .p_c_rfw(a_p_c_rfw), .p_c_drw(a_p_c_drw),
    .p_c_wbsource(a_p_c_wbsource), .p_c_alusrc(a_p_c_alusrc), .p_jalra(a_p_jalra));

  cpu_id_pipe #(.NREG(16), .BYPASS(0), .RF_RESET(1)) u_b (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .wb_rfw(wb_rfw), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
    .id_stall(b_id_stall), .redirect(b_redirect), .redirect_pc(b_redirect_pc),
    .p_valid(b_p_valid), .p_opcode(b_p_opcode), .p_rfa(b_p_rfa), .p_rfb(b_p_rfb),
    .p_imm(b_p_imm), .p_rf_waddr(b_p_rf_waddr), .p_c_rfw(b_p_c_rfw), .p_c_drw(b_p_c_drw),
    .p_c_wbsource(b_p_c_wbsource), .p_c_alusrc(b_p_c_alusrc), .p_jalra(b_p_jalra));

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_rfw      = en;
    wb_rf_waddr = addr;
    wb_rf_wdata = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'h200, enc_j(6'h03, 26'h40));
    checks++; if (a_redirect !== 1'b0) begin failures++; $display("FAIL rst_redirect got=%0b exp=0", a_redirect); end
    checks++; if (a_redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_redirect_pc got=%h exp=0", a_redirect_pc); end
    checks++; if (a_id_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", a_id_stall); end
    tick();
    checks++; if (a_p_valid !== 1'b0 || a_p_jalra !== 32'h0) begin failures++; $display("FAIL rst_p_a got=%0b/%h exp=0/0", a_p_valid, a_p_jalra); end
    checks++; if (b_p_valid !== 1'b0 || b_p_rf_waddr !== 5'd0) begin failures++; $display("FAIL rst_p_b got=%0b/%0d exp=0/0", b_p_valid, b_p_rf_waddr); end
    drive(1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    tick();
    // r7 of the reset-cleared instance
    drive(1'b1, 32'h8, enc_r(5'd7, 5'd0, 5'd8, 6'h21));
    tick();
    checks++; if (b_p_rfa !== 32'h0 || b_p_valid !== 1'b1) begin failures++; $display("FAIL rfreset_r7 got=%h/%0b exp=0/1", b_p_rfa, b_p_valid); end
  endtask

  task automatic test_writeback();
    drive(1'b0, 32'h0, 32'h0);
    wb(1'b1, 5'd1, 32'h11); tick();
    wb(1'b1, 5'd2, 32'h22); tick();
    wb(1'b1, 5'd4, 32'h4);  tick();
    wb(1'b1, 5'd5, 32'h55); tick();
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h10, enc_r(5'd1, 5'd4, 5'd9, 6'h21));
    checks++; if (a_id_stall !== 1'b0 || b_id_stall !== 1'b0) begin failures++; $display("FAIL rd_stall got=%0b%0b exp=00", a_id_stall, b_id_stall); end
    tick();
    checks++; if (a_p_rfa !== 32'h11 || a_p_rfb !== 32'h4) begin failures++; $display("FAIL rd_ops got=%h/%h exp=11/4", a_p_rfa, a_p_rfb); end
    checks++; if (a_p_rf_waddr !== 5'd9 || a_p_c_rfw !== 1'b1 || a_p_c_alusrc !== 1'b0) begin failures++; $display("FAIL rd_ctl got=%0d/%0b/%0b exp=9/1/0", a_p_rf_waddr, a_p_c_rfw, a_p_c_alusrc); end
    checks++; if (a_p_imm !== 32'h4821 || a_p_jalra !== 32'h14) begin failures++; $display("FAIL rd_imm got=%h/%h exp=4821/14", a_p_imm, a_p_jalra); end
    checks++; if (b_p_rfa !== 32'h11 || b_p_valid !== 1'b1) begin failures++; $display("FAIL rd_b got=%h/%0b exp=11/1", b_p_rfa, b_p_valid); end
  endtask

  task automatic test_bypass();
    wb(1'b1, 5'd5, 32'h1234);
    drive(1'b1, 32'h20, enc_r(5'd5, 5'd0, 5'd6, 6'h21));
    checks++; if (a_id_stall !== 1'b0) begin failures++; $display("FAIL byp_a_stall got=%0b exp=0", a_id_stall); end
    checks++; if (b_id_stall !== 1'b1) begin failures++; $display("FAIL byp_b_stall got=%0b exp=1", b_id_stall); end
    tick();
    checks++; if (a_p_rfa !== 32'h1234 || a_p_valid !== 1'b1) begin failures++; $display("FAIL byp_a_rfa got=%h/%0b exp=1234/1", a_p_rfa, a_p_valid); end
    checks++; if (b_p_valid !== 1'b0) begin failures++; $display("FAIL byp_b_bubble got=%0b exp=0", b_p_valid); end
    wb(1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (b_id_stall !== 1'b0) begin failures++; $display("FAIL byp_b_release got=%0b exp=0", b_id_stall); end
    tick();
    checks++; if (b_p_rfa !== 32'h1234 || b_p_valid !== 1'b1) begin failures++; $display("FAIL byp_b_rfa got=%h/%0b exp=1234/1", b_p_rfa, b_p_valid); end
    checks++; if (a_p_rfa !== 32'h1234) begin failures++; $display("FAIL byp_a_rf got=%h exp=1234", a_p_rfa); end
    // a write to r0 is neither forwarded nor a hazard
    wb(1'b1, 5'd0, 32'hDEAD);
    drive(1'b1, 32'h24, enc_r(5'd0, 5'd0, 5'd6, 6'h21));
    checks++; if (b_id_stall !== 1'b0) begin failures++; $display("FAIL r0_b_stall got=%0b exp=0", b_id_stall); end
    tick();
    checks++; if (a_p_rfa !== 32'h0) begin failures++; $display("FAIL r0_a_rfa got=%h exp=0", a_p_rfa); end
    wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_imm();
    drive(1'b1, 32'h30, enc_i(6'h08, 5'd1, 5'd10, 16'hFFF0));
    tick();
    checks++; if (a_p_imm !== 32'hFFFFFFF0 || a_p_c_alusrc !== 1'b1) begin failures++; $display("FAIL addi_imm got=%h/%0b exp=fffffff0/1", a_p_imm, a_p_c_alusrc); end
    checks++; if (a_p_rf_waddr !== 5'd10 || a_p_c_rfw !== 1'b1 || a_p_rfa !== 32'h11) begin failures++; $display("FAIL addi_ctl got=%0d/%0b/%h exp=10/1/11", a_p_rf_waddr, a_p_c_rfw, a_p_rfa); end
    drive(1'b1, 32'h34, enc_i(6'h0d, 5'd1, 5'd11, 16'hFFF0));
    tick();
    checks++; if (a_p_imm !== 32'h0000FFF0 || a_p_opcode !== 6'h0d) begin failures++; $display("FAIL ori_imm got=%h/%h exp=0000fff0/0d", a_p_imm, a_p_opcode); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h40, enc_i(6'h23, 5'd1, 5'd2, 16'h4));
    checks++; if (a_id_stall !== 1'b0) begin failures++; $display("FAIL lw_stall got=%0b exp=0", a_id_stall); end
    tick();
    checks++; if (a_p_c_wbsource !== 2'b01 || a_p_rf_waddr !== 5'd2 || a_p_c_alusrc !== 1'b1 || a_p_c_rfw !== 1'b1) begin failures++; $display("FAIL lw_ctl got=%0d/%0d/%0b/%0b exp=1/2/1/1", a_p_c_wbsource, a_p_rf_waddr, a_p_c_alusrc, a_p_c_rfw); end
    drive(1'b1, 32'h44, enc_r(5'd2, 5'd4, 5'd3, 6'h21));
    checks++; if (a_id_stall !== 1'b1 || b_id_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b%0b exp=11", a_id_stall, b_id_stall); end
    tick();
    checks++; if (a_p_valid !== 1'b0 || a_p_c_rfw !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%0b/%0b exp=0/0", a_p_valid, a_p_c_rfw); end
    checks++; if (a_id_stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%0b exp=0", a_id_stall); end
    tick();
    checks++; if (a_p_valid !== 1'b1 || a_p_rf_waddr !== 5'd3 || a_p_rfa !== 32'h22) begin failures++; $display("FAIL lu_issue got=%0b/%0d/%h exp=1/3/22", a_p_valid, a_p_rf_waddr, a_p_rfa); end
    // rt of an immediate op is a destination, not a source
    drive(1'b1, 32'h48, enc_i(6'h23, 5'd1, 5'd2, 16'h4)); tick();
    drive(1'b1, 32'h4c, enc_i(6'h08, 5'd1, 5'd2, 16'h1));
    checks++; if (a_id_stall !== 1'b0) begin failures++; $display("FAIL lu_rt_dest got=%0b exp=0", a_id_stall); end
    tick();
    drive(1'b1, 32'h50, enc_i(6'h23, 5'd1, 5'd2, 16'h4)); tick();
    drive(1'b1, 32'h54, enc_i(6'h2b, 5'd1, 5'd2, 16'hFFFC));
    checks++; if (a_id_stall !== 1'b1) begin failures++; $display("FAIL lu_sw_rt got=%0b exp=1", a_id_stall); end
    tick(); tick();
    checks++; if (a_p_c_drw !== 1'b1 || a_p_c_rfw !== 1'b0 || a_p_imm !== 32'hFFFFFFFC || a_p_rfb !== 32'h22) begin failures++; $display("FAIL sw_ctl got=%0b/%0b/%h/%h exp=1/0/fffffffc/22", a_p_c_drw, a_p_c_rfw, a_p_imm, a_p_rfb); end
    drive(1'b1, 32'h58, enc_i(6'h23, 5'd1, 5'd2, 16'h4)); tick();
    drive(1'b1, 32'h5c, enc_i(6'h04, 5'd2, 5'd2, 16'h3));
    checks++; if (a_id_stall !== 1'b1 || a_redirect !== 1'b0) begin failures++; $display("FAIL lu_beq got=%0b/%0b exp=1/0", a_id_stall, a_redirect); end
    tick();
    drive(1'b0, 32'h0, 32'h0); tick();
  endtask

  task automatic test_branch();
    drive(1'b1, 32'h100, enc_i(6'h04, 5'd1, 5'd1, 16'h3));
    checks++; if (a_redirect !== 1'b1 || a_redirect_pc !== 32'h110 || a_id_stall !== 1'b0) begin failures++; $display("FAIL beq_taken got=%0b/%h/%0b exp=1/110/0", a_redirect, a_redirect_pc, a_id_stall); end
    checks++; if (b_redirect !== 1'b1 || b_redirect_pc !== 32'h110) begin failures++; $display("FAIL beq_taken_b got=%0b/%h exp=1/110", b_redirect, b_redirect_pc); end
    tick();
    drive(1'b1, 32'h104, enc_r(5'd1, 5'd4, 5'd9, 6'h21));
    checks++; if (a_redirect !== 1'b0 || a_id_stall !== 1'b0) begin failures++; $display("FAIL kill_comb got=%0b/%0b exp=0/0", a_redirect, a_id_stall); end
    tick();
    checks++; if (a_p_valid !== 1'b0) begin failures++; $display("FAIL kill_bubble got=%0b exp=0", a_p_valid); end
    drive(1'b1, 32'h110, enc_i(6'h05, 5'd1, 5'd1, 16'h5));
    checks++; if (a_redirect !== 1'b0) begin failures++; $display("FAIL bne_not_taken got=%0b exp=0", a_redirect); end
    tick();
    checks++; if (a_p_valid !== 1'b1 || a_p_c_rfw !== 1'b0) begin failures++; $display("FAIL bne_issue got=%0b/%0b exp=1/0", a_p_valid, a_p_c_rfw); end
    drive(1'b1, 32'h114, enc_i(6'h05, 5'd1, 5'd4, 16'hFFFF));
    checks++; if (a_redirect !== 1'b1 || a_redirect_pc !== 32'h114) begin failures++; $display("FAIL bne_back got=%0b/%h exp=1/114", a_redirect, a_redirect_pc); end
    tick();
    drive(1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 32'h120, enc_i(6'h08, 5'd1, 5'd4, 16'h4)); tick();
    drive(1'b1, 32'h124, enc_i(6'h04, 5'd4, 5'd4, 16'h2));
    checks++; if (a_id_stall !== 1'b1 || a_redirect !== 1'b0) begin failures++; $display("FAIL br_hz got=%0b/%0b exp=1/0", a_id_stall, a_redirect); end
    tick();
    checks++; if (a_id_stall !== 1'b0 || a_redirect !== 1'b1 || a_redirect_pc !== 32'h130) begin failures++; $display("FAIL br_hz_go got=%0b/%0b/%h exp=0/1/130", a_id_stall, a_redirect, a_redirect_pc); end
    tick();
    drive(1'b0, 32'h0, 32'h0); tick();
  endtask

  task automatic test_jump();
    drive(1'b1, 32'h200, enc_j(6'h03, 26'h40));
    checks++; if (a_redirect !== 1'b1 || a_redirect_pc !== 32'h100) begin failures++; $display("FAIL jal_target got=%0b/%h exp=1/100", a_redirect, a_redirect_pc); end
    tick();
    checks++; if (a_p_rf_waddr !== 5'd31 || a_p_jalra !== 32'h204 || a_p_c_wbsource !== 2'b10 || a_p_c_rfw !== 1'b1 || a_p_valid !== 1'b1) begin failures++; $display("FAIL jal_link got=%0d/%h/%0d/%0b/%0b exp=31/204/2/1/1", a_p_rf_waddr, a_p_jalra, a_p_c_wbsource, a_p_c_rfw, a_p_valid); end
    drive(1'b1, 32'h204, enc_r(5'd5, 5'd0, 5'd0, 6'h08));
    checks++; if (a_redirect !== 1'b0) begin failures++; $display("FAIL jal_kill got=%0b exp=0", a_redirect); end
    tick();
    drive(1'b1, 32'h100, enc_r(5'd5, 5'd0, 5'd0, 6'h08));
    checks++; if (a_redirect !== 1'b1 || a_redirect_pc !== 32'h1234) begin failures++; $display("FAIL jr_target got=%0b/%h exp=1/1234", a_redirect, a_redirect_pc); end
    tick();
    checks++; if (a_p_valid !== 1'b1 || a_p_c_rfw !== 1'b0) begin failures++; $display("FAIL jr_issue got=%0b/%0b exp=1/0", a_p_valid, a_p_c_rfw); end
    drive(1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 32'hF0000000, enc_j(6'h02, 26'h3FFFFFF));
    checks++; if (a_redirect_pc !== 32'hFFFFFFFC) begin failures++; $display("FAIL j_region got=%h exp=fffffffc", a_redirect_pc); end
    tick();
    drive(1'b0, 32'h0, 32'h0); tick();
  endtask

  task automatic test_bubbles();
    drive(1'b1, 32'h300, {6'h3F, 26'h0});
    tick();
    checks++; if (a_p_valid !== 1'b0 || a_p_c_rfw !== 1'b0 || a_p_c_drw !== 1'b0) begin failures++; $display("FAIL undef got=%0b/%0b/%0b exp=0/0/0", a_p_valid, a_p_c_rfw, a_p_c_drw); end
    drive(1'b1, 32'h304, enc_i(6'h23, 5'd1, 5'd2, 16'h4)); tick();
    drive(1'b0, 32'h308, enc_r(5'd2, 5'd0, 5'd3, 6'h21));
    checks++; if (a_id_stall !== 1'b0) begin failures++; $display("FAIL invalid_stall got=%0b exp=0", a_id_stall); end
    drive(1'b0, 32'h308, enc_j(6'h03, 26'h40));
    checks++; if (a_redirect !== 1'b0) begin failures++; $display("FAIL invalid_redirect got=%0b exp=0", a_redirect); end
    tick();
    checks++; if (a_p_valid !== 1'b0) begin failures++; $display("FAIL invalid_bubble got=%0b exp=0", a_p_valid); end
  endtask

  task automatic test_nreg();
    drive(1'b0, 32'h0, 32'h0);
    wb(1'b1, 5'd20, 32'hFFFF); tick();
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h400, enc_r(5'd20, 5'd0, 5'd9, 6'h21));
    tick();
    checks++; if (a_p_rfa !== 32'hFFFF) begin failures++; $display("FAIL nreg_a_r20 got=%h exp=ffff", a_p_rfa); end
    checks++; if (b_p_rfa !== 32'h0) begin failures++; $display("FAIL nreg_b_r20 got=%h exp=0", b_p_rfa); end
  endtask

  task automatic test_midreset();
    drive(1'b1, 32'h500, enc_r(5'd5, 5'd4, 5'd9, 6'h21));
    tick();
    checks++; if (a_p_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0b exp=1", a_p_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_p_valid !== 1'b0 || a_p_rfa !== 32'h0 || a_p_rf_waddr !== 5'd0 || a_p_c_rfw !== 1'b0 || a_p_jalra !== 32'h0) begin failures++; $display("FAIL mid_rst_a got=%0b/%h/%0d/%0b/%h exp=0/0/0/0/0", a_p_valid, a_p_rfa, a_p_rf_waddr, a_p_c_rfw, a_p_jalra); end
    checks++; if (b_p_valid !== 1'b0 || b_p_rfa !== 32'h0) begin failures++; $display("FAIL mid_rst_b got=%0b/%h exp=0/0", b_p_valid, b_p_rfa); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h504, enc_r(5'd5, 5'd4, 5'd9, 6'h21));
    tick();
    checks++; if (a_p_rfa !== 32'h1234 || a_p_rfb !== 32'h4) begin failures++; $display("FAIL mid_keep_a got=%h/%h exp=1234/4", a_p_rfa, a_p_rfb); end
    checks++; if (b_p_rfa !== 32'h0 || b_p_rfb !== 32'h0) begin failures++; $display("FAIL mid_clear_b got=%h/%h exp=0/0", b_p_rfa, b_p_rfb); end
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_bypass();
    test_imm();
    test_load_use();
    test_branch();
    test_jump();
    test_bubbles();
    test_nreg();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
